// File: rtl/npc_pkg.sv
// Shared fetch-side definitions: IFU state encoding, word sizes and default reset PC.
// The FAULT state only exists when IFU_MISALIGN_EN is defined.
package npc_pkg;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

`ifdef IFU_MISALIGN_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_FAULT = 3'd4
   } ifu_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3
   } ifu_state_t;
`endif

   // Sequential successor of a fetch address; wraps modulo 2^XLEN.
   function automatic logic [XLEN-1:0] pc_seq_next(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INST_BYTES);
   endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding imem fetch, one-entry instruction register, redirects.
// Optional misaligned-target fault handling is enabled by defining IFU_MISALIGN_EN.
module ifu
   import npc_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
`ifdef IFU_MISALIGN_EN
   ,
   output logic            fetch_fault
`endif
);

   ifu_state_t      r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_drop;
   logic            r_inst_valid;
   logic [XLEN-1:0] r_inst;
   logic [XLEN-1:0] r_inst_pc;

   ifu_state_t      w_state_n;
   logic [XLEN-1:0] w_pc_n;
   logic            w_drop_n;
   logic            w_inst_valid_n;
   logic            w_load_inst;
   logic [XLEN-1:0] w_tgt;

`ifdef IFU_MISALIGN_EN
   logic r_fault;
   logic w_fault_n;
   logic w_misalign;

   assign w_tgt      = redirect_pc;
   assign w_misalign = |redirect_pc[1:0];
`else
   // Low target bits are meaningless without fault support; they are dropped on load.
   logic w_unused_lo;

   assign w_tgt       = {redirect_pc[XLEN-1:2], 2'b00};
   assign w_unused_lo = ^redirect_pc[1:0];
`endif

   always_comb begin
      w_state_n      = r_state;
      w_pc_n         = r_pc;
      w_drop_n       = r_drop;
      w_inst_valid_n = r_inst_valid;
      w_load_inst    = 1'b0;
`ifdef IFU_MISALIGN_EN
      w_fault_n      = r_fault;
`endif
      if (redirect_valid) begin
         // Redirect wins; an in-flight request keeps WAIT but its response is marked for discard.
         w_pc_n         = w_tgt;
         w_inst_valid_n = 1'b0;
         case (r_state)
            ST_REQ: begin
               if (imem_gnt) begin
                  w_state_n = ST_WAIT;
                  w_drop_n  = 1'b1;
               end else begin
                  w_state_n = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  w_state_n = ST_REQ;
                  w_drop_n  = 1'b0;
               end else begin
                  w_drop_n  = 1'b1;
               end
            end
            default: w_state_n = ST_REQ;
         endcase
`ifdef IFU_MISALIGN_EN
         w_fault_n = 1'b0;
         if (w_misalign) begin
            w_state_n = ST_FAULT;
            w_drop_n  = 1'b0;
            w_fault_n = 1'b1;
         end
`endif
      end else begin
         case (r_state)
            ST_IDLE: w_state_n = ST_REQ;
            ST_REQ: begin
               if (imem_gnt) w_state_n = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  if (r_drop) begin
                     w_drop_n  = 1'b0;
                     w_state_n = ST_REQ;
                  end else begin
                     w_load_inst    = 1'b1;
                     w_inst_valid_n = 1'b1;
                     w_state_n      = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (inst_ready) begin
                  w_pc_n         = pc_seq_next(r_pc);
                  w_inst_valid_n = 1'b0;
                  w_state_n      = ST_REQ;
               end
            end
`ifdef IFU_MISALIGN_EN
            ST_FAULT: w_state_n = ST_FAULT;
`endif
            default: w_state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC;
         r_drop       <= 1'b0;
         r_inst_valid <= 1'b0;
         r_inst       <= '0;
         r_inst_pc    <= '0;
      end else begin
         r_state      <= w_state_n;
         r_pc         <= w_pc_n;
         r_drop       <= w_drop_n;
         r_inst_valid <= w_inst_valid_n;
         if (w_load_inst) begin
            r_inst    <= imem_rdata;
            r_inst_pc <= r_pc;
         end
      end
   end

`ifdef IFU_MISALIGN_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_fault <= 1'b0;
      else        r_fault <= w_fault_n;
   end

   assign fetch_fault = r_fault;
`endif

   assign imem_req   = (r_state == ST_REQ);
   assign imem_addr  = r_pc;
   assign inst_valid = r_inst_valid;
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios with literal expectations, then randomized traffic against a
// transaction-level model. Build with IFU_MISALIGN_EN defined to cover the fault path.
module tb_ifu;

   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
`ifdef IFU_MISALIGN_EN
   logic        fetch_fault;
`endif

   always #5 clk = ~clk;

   ifu #(.RESET_PC(RPC)) dut (
      .clk(clk),
      .reset(reset),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .inst(inst),
      .inst_pc(inst_pc)
`ifdef IFU_MISALIGN_EN
      ,
      .fetch_fault(fetch_fault)
`endif
   );

   int   n_chk = 0;
   int   n_err = 0;
   logic chk_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: a fetch is either idle-after-reset, faulted, awaiting grant,
   // outstanding (possibly to be thrown away), or delivered and waiting for decode.
   logic [31:0] m_pc = RPC;
   logic        m_idle = 1'b1;
   logic        m_outst = 1'b0;
   logic        m_disc = 1'b0;
   logic        m_hv = 1'b0;
   logic [31:0] m_inst = '0;
   logic [31:0] m_ipc = '0;
   logic        m_fault = 1'b0;

   function automatic logic m_req();
      return !m_idle && !m_outst && !m_hv && !m_fault;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc = RPC; m_idle = 1'b1; m_outst = 1'b0; m_disc = 1'b0;
         m_hv = 1'b0; m_inst = '0; m_ipc = '0; m_fault = 1'b0;
      end else if (redirect_valid) begin
         logic [31:0] tgt;
         logic        mis;
         logic        asking;
         asking = m_req();
`ifdef IFU_MISALIGN_EN
         tgt = redirect_pc;
         mis = (redirect_pc % 4) != 0;
`else
         tgt = redirect_pc - (redirect_pc % 4);
         mis = 1'b0;
`endif
         m_pc = tgt; m_hv = 1'b0; m_idle = 1'b0;
         if (mis) begin
            m_fault = 1'b1; m_outst = 1'b0; m_disc = 1'b0;
         end else begin
            m_fault = 1'b0;
            if (asking && imem_gnt) begin
               m_outst = 1'b1; m_disc = 1'b1;
            end else if (m_outst && !imem_rvalid) begin
               m_disc = 1'b1;
            end else if (m_outst) begin
               m_outst = 1'b0; m_disc = 1'b0;
            end
         end
      end else if (m_idle) begin
         m_idle = 1'b0;
      end else if (m_fault) begin
         m_fault = 1'b1;
      end else if (m_hv) begin
         if (inst_ready) begin
            m_hv = 1'b0;
            m_pc = m_pc + 4;
         end
      end else if (m_outst) begin
         if (imem_rvalid) begin
            if (!m_disc) begin
               m_hv = 1'b1; m_inst = imem_rdata; m_ipc = m_pc;
            end
            m_outst = 1'b0; m_disc = 1'b0;
         end
      end else if (imem_gnt) begin
         m_outst = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("imem_req", imem_req, m_req());
         chk("imem_addr", imem_addr, m_pc);
         chk("inst_valid", inst_valid, m_hv);
         chk("inst", inst, m_inst);
         chk("inst_pc", inst_pc, m_ipc);
`ifdef IFU_MISALIGN_EN
         chk("fetch_fault", fetch_fault, m_fault);
`endif
      end
   end

   task automatic cyc(input logic rv, input logic [31:0] rpc, input logic g, input logic rvl,
                      input logic [31:0] rd, input logic rdy);
      redirect_valid = rv; redirect_pc = rpc; imem_gnt = g;
      imem_rvalid = rvl; imem_rdata = rd; inst_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 chk_on = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      reset = 1'b1;

      // Basic fetch with minimum latency
      cyc(0, 0, 0, 0, 0, 0);
      chk("d_req0", imem_req, 1);
      chk("d_addr0", imem_addr, 32'h8000_0000);
      cyc(0, 0, 1, 0, 0, 0);
      chk("d_wait_req", imem_req, 0);
      cyc(0, 0, 0, 1, 32'h0010_0073, 0);
      chk("d_valid", inst_valid, 1);
      chk("d_inst", inst, 32'h0010_0073);
      chk("d_inst_pc", inst_pc, 32'h8000_0000);

      // Backpressure
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 0, 0, 32'hFFFF_FFFF, 0);
         chk("bp_valid", inst_valid, 1);
         chk("bp_inst", inst, 32'h0010_0073);
         chk("bp_inst_pc", inst_pc, 32'h8000_0000);
         chk("bp_req", imem_req, 0);
         chk("bp_addr", imem_addr, 32'h8000_0000);
      end
      cyc(0, 0, 0, 0, 0, 1);
      chk("hs_valid", inst_valid, 0);
      chk("hs_addr", imem_addr, 32'h8000_0004);
      chk("hs_req", imem_req, 1);

      // Redirect while waiting: response dropped
      cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 32'h8000_0100, 0, 0, 0, 0);
      chk("drop_valid0", inst_valid, 0);
      chk("drop_req0", imem_req, 0);
      cyc(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
      chk("drop_valid1", inst_valid, 0);
      chk("drop_req1", imem_req, 1);
      chk("drop_addr", imem_addr, 32'h8000_0100);
      chk("mdl_pc_drop", m_pc, 32'h8000_0100);

      // Redirect coincident with handshake in HOLD
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 32'h1234_5678, 0);
      chk("hr_inst", inst, 32'h1234_5678);
      chk("hr_inst_pc", inst_pc, 32'h8000_0100);
      cyc(1, 32'h8000_0040, 0, 0, 0, 1);
      chk("hr_valid", inst_valid, 0);
      chk("hr_addr", imem_addr, 32'h8000_0040);
      chk("hr_req", imem_req, 1);

      // PC wrap
      cyc(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 32'h0000_0013, 0);
      chk("wr_inst_pc", inst_pc, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 0, 0, 1);
      chk("wr_addr1", imem_addr, 32'h0000_0000);

`ifdef IFU_MISALIGN_EN
      cyc(1, 32'h8000_0002, 0, 0, 0, 0);
      chk("mf_fault0", fetch_fault, 1);
      chk("mf_req0", imem_req, 0);
      cyc(0, 0, 1, 0, 0, 1);
      chk("mf_fault1", fetch_fault, 1);
      chk("mf_req1", imem_req, 0);
      cyc(1, 32'h8000_0008, 0, 0, 0, 0);
      chk("mf_fault2", fetch_fault, 0);
      chk("mf_req2", imem_req, 1);
      chk("mf_addr", imem_addr, 32'h8000_0008);
`else
      cyc(1, 32'h8000_0102, 0, 0, 0, 0);
      chk("al_addr", imem_addr, 32'h8000_0100);
`endif

      // Reset mid-transaction, late rvalid ignored
      cyc(0, 0, 1, 0, 0, 0);
      reset = 1'b0;
      #1;
      chk("mr_req", imem_req, 0);
      chk("mr_addr", imem_addr, RPC);
      chk("mr_valid", inst_valid, 0);
      @(negedge clk);
      #1 reset = 1'b1;
      cyc(0, 0, 0, 1, 32'hCAFE_0001, 0);
      chk("mr_late_valid", inst_valid, 0);
      chk("mr_late_req", imem_req, 1);
      chk("mr_late_addr", imem_addr, RPC);

      // Randomized traffic checked against the model every cycle
      for (int i = 0; i < 3000; i++) begin
         logic        rv, g, rvl, rdy;
         logic [31:0] rpc, r;
         r   = $urandom;
         rv  = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 7))
            0:       rpc = 32'hFFFF_FFFC;
            1:       rpc = r;
            default: rpc = r & 32'hFFFF_FFFC;
         endcase
         g   = $urandom_range(0, 1) == 1;
         rvl = m_outst ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
         rdy = $urandom_range(0, 9) < 6;
         if (i % 700 == 350) begin
            reset = 1'b0;
            #2;
            @(negedge clk);
            #1 reset = 1'b1;
         end
         cyc(rv, rpc, g, rvl, $urandom, rdy);
      end

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
